// File: rtl/seq_signed_layer_mult.sv
// seq_signed_layer_mult: iterative signed A x B multiplier.
// The multiplier B is consumed one two-bit "layer" per clock. Each layer forms the
// exact signed partial product a * {b_hi,b_lo}, which is shifted and accumulated.
// When approx_en is sampled high with the operands, the lowest APPROX_LAYERS layers
// are skipped. That is the same as zeroing the low 2*APPROX_LAYERS bits of b.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand request
//   in_ready   block can accept operands (registered, high in IDLE)
//   a          signed multiplicand, WA bits
//   b          signed multiplier, WB bits
//   approx_en  sampled with operands; 1 skips the low APPROX_LAYERS layers
//   out_valid  product valid (registered)
//   out_ready  consumer accepts product
//   product    signed result, WA+WB bits, held stable while out_valid
//   busy       high while in RUN or DONE
module seq_signed_layer_mult #(
    parameter int unsigned WA            = 8,
    parameter int unsigned WB            = 8,
    parameter int unsigned APPROX_LAYERS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WA-1:0]     a,
    input  logic [WB-1:0]     b,
    input  logic              approx_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WA+WB-1:0]  product,
    output logic              busy
);

    localparam int unsigned L  = WB / 2;
    localparam int unsigned WP = WA + WB;
    localparam int unsigned IW = (L > 1) ? $clog2(L) : 1;
    localparam int unsigned SW = $clog2(WB);
    localparam int unsigned WL = WA + 2;

    // Reject parameter sets the layer decomposition cannot represent.
    if ((WB % 2) != 0 || WB < 2 || WA < 2 || APPROX_LAYERS >= L) begin : g_param_check
        $error("seq_signed_layer_mult: illegal WA/WB/APPROX_LAYERS combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                  state, state_d;
    logic signed [WA-1:0]    a_q, a_d;
    logic        [WB-1:0]    b_q, b_d;
    logic        [IW-1:0]    idx, idx_d;
    logic signed [WP-1:0]    acc, acc_d;
    logic        [WP-1:0]    product_d;
    logic                    out_valid_d;
    logic                    in_ready_d;
    logic                    busy_d;

    logic                    last_layer;
    logic        [SW-1:0]    shamt;
    logic        [1:0]       pair_bits;
    logic signed [2:0]       pair;
    logic signed [WL-1:0]    a_ext;
    logic signed [WL-1:0]    pair_ext;
    logic signed [WL-1:0]    layer;
    logic signed [WP-1:0]    layer_sh;

    // Layer datapath: only the top layer treats its bit pair as signed (-2..1).
    always_comb begin
        last_layer = (idx == IW'(L - 1));
        shamt      = SW'({idx, 1'b0});
        pair_bits  = b_q[shamt +: 2];
        pair       = {last_layer ? pair_bits[1] : 1'b0, pair_bits};
        a_ext      = WL'(a_q);
        pair_ext   = WL'(pair);
        layer      = a_ext * pair_ext;
        layer_sh   = WP'(layer) <<< shamt;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx       <= '0;
            acc       <= '0;
            product   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx       <= idx_d;
            acc       <= acc_d;
            product   <= product_d;
            out_valid <= out_valid_d;
            in_ready  <= in_ready_d;
            busy      <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        a_d         = a_q;
        b_d         = b_q;
        idx_d       = idx;
        acc_d       = acc;
        product_d   = product;
        out_valid_d = out_valid;
        in_ready_d  = in_ready;
        busy_d      = busy;

        case (state)
            ST_IDLE: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
                if (in_valid && in_ready) begin
                    a_d        = a;
                    b_d        = b;
                    idx_d      = approx_en ? IW'(APPROX_LAYERS) : '0;
                    acc_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc + layer_sh;
                idx_d = idx + IW'(1);
                if (last_layer) begin
                    product_d   = acc + layer_sh;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_signed_layer_mult.sv
// Directed and randomised checks for seq_signed_layer_mult (WA=WB=8, APPROX_LAYERS=1).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seq_signed_layer_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        approx_en;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int tests = 0;
    int fails = 0;

    seq_signed_layer_mult #(.WA(8), .WB(8), .APPROX_LAYERS(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .approx_en(approx_en), .out_valid(out_valid),
        .out_ready(out_ready), .product(product), .busy(busy)
    );

    always #5 clk = ~clk;

    // One operation with out_ready held high. Latency counts rising edges from the
    // accepting edge (inclusive) up to the edge that raises out_valid.
    task automatic run_op(input logic signed [7:0] ta, input logic signed [7:0] tbv,
                          input logic tap, output logic [15:0] prod,
                          output int edges, output int ir_bad);
        int guard;
        ir_bad = 0;
        edges  = 0;
        guard  = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        a = ta; b = tbv; approx_en = tap; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        approx_en = 1'($urandom);
        while (!out_valid && edges < 50) begin
            if (in_ready) ir_bad++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (in_ready) ir_bad++;
        prod = product;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; approx_en = 1'b0;
        #2;
        tests++;
        if (out_valid !== 1'b0 || product !== 16'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: out_valid=%b product=%h in_ready=%b busy=%b, required 0/0000/1/0",
                     out_valid, product, in_ready, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_min_operands();
        logic [15:0] p; int lat; int irb;
        run_op(-8'sd128, -8'sd128, 1'b0, p, lat, irb);
        tests++;
        if (p !== 16'(16384)) begin
            fails++; $display("FAIL min_product: got %0d, required 16384", $signed(p));
        end
        tests++;
        if (lat !== 5) begin
            fails++; $display("FAIL exact_latency: got %0d edges, required 5", lat);
        end
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL post_handshake: in_ready=%b out_valid=%b busy=%b, required 1/0/0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] p; int lat; int irb;
        run_op(8'sd127, -8'sd1, 1'b0, p, lat, irb);
        tests++;
        if (p !== 16'(-127)) begin
            fails++; $display("FAIL b2b_first: got %0d, required -127", $signed(p));
        end
        tests++;
        if (irb !== 0) begin
            fails++; $display("FAIL b2b_first_in_ready: in_ready high in %0d busy cycles, required 0", irb);
        end
        run_op(-8'sd3, 8'sd5, 1'b0, p, lat, irb);
        tests++;
        if (p !== 16'(-15)) begin
            fails++; $display("FAIL b2b_second: got %0d, required -15", $signed(p));
        end
        tests++;
        if (irb !== 0) begin
            fails++; $display("FAIL b2b_second_in_ready: in_ready high in %0d busy cycles, required 0", irb);
        end
    endtask

    task automatic test_approx();
        logic [15:0] p; int lat; int irb;
        run_op(8'sd5, 8'sd7, 1'b1, p, lat, irb);
        tests++;
        if (p !== 16'(20)) begin
            fails++; $display("FAIL approx_product: got %0d, required 20", $signed(p));
        end
        tests++;
        if (lat !== 4) begin
            fails++; $display("FAIL approx_latency: got %0d edges, required 4", lat);
        end
    endtask

    task automatic test_stall();
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
        a = 8'(10); b = 8'(-6); approx_en = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 8'(3); b = 8'(3);
        guard = 0;
        while (!out_valid && guard < 50) begin @(negedge clk); guard++; end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (out_valid !== 1'b1 || product !== 16'(-60) || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold[%0d]: out_valid=%b product=%0d in_ready=%b, required 1/-60/0",
                         i, out_valid, $signed(product), in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_reaccept: busy=%b in_ready=%b, required 1/0", busy, in_ready);
        end
        guard = 0;
        while (!out_valid && guard < 50) begin @(negedge clk); guard++; end
        tests++;
        if (product !== 16'(9) || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL stall_new_op: product=%0d out_valid=%b, required 9/1", $signed(product), out_valid);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] p; int lat; int irb; int pulses; int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
        a = 8'(50); b = 8'(50); approx_en = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || product !== 16'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: out_valid=%b product=%h in_ready=%b busy=%b, required 0/0000/1/0",
                     out_valid, product, in_ready, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        tests++;
        if (pulses !== 0) begin
            fails++; $display("FAIL reset_lost_op: out_valid seen %0d times, required 0", pulses);
        end
        run_op(-8'sd7, 8'sd9, 1'b0, p, lat, irb);
        tests++;
        if (p !== 16'(-63)) begin
            fails++; $display("FAIL after_reset_op: got %0d, required -63", $signed(p));
        end
    endtask

    task automatic test_random();
        logic [15:0] q[$];
        logic [15:0] exp;
        logic signed [7:0] sa;
        logic signed [7:0] sb;
        int accepted;
        int got;
        int cyc;
        accepted = 0; got = 0; cyc = 0;
        while ((accepted < 2000 || q.size() > 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (accepted < 2000) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                a         = 8'($urandom);
                b         = 8'($urandom);
                approx_en = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (accepted >= 2000) || ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) begin
                sa  = a;
                sb  = approx_en ? (b & 8'hFC) : b;
                exp = 16'(int'(sa) * int'(sb));
                q.push_back(exp);
                accepted++;
            end
            if (out_valid && out_ready) begin
                tests++;
                got++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL rand_extra_result: product=%h with no pending op", product);
                end else begin
                    exp = q.pop_front();
                    if (product !== exp) begin
                        fails++;
                        $display("FAIL rand_result[%0d]: got %0d, required %0d", got, $signed(product), $signed(exp));
                    end
                end
            end
        end
        in_valid = 1'b0;
        tests++;
        if (accepted != 2000 || got != 2000 || q.size() != 0) begin
            fails++;
            $display("FAIL rand_count: accepted=%0d results=%0d pending=%0d, required 2000/2000/0",
                     accepted, got, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_min_operands();
        test_back_to_back();
        test_approx();
        test_stall();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
